pec_snapshot_controller: RTL
============================

// Module: pec_snapshot_controller
// PURPOSE
//  Sequences the performance event counter bank: decides when to snapshot all
//  counters, clears them without losing events, and hands the snapshot to the
//  DMA packer over a valid/ready handshake. Capture triggers: external, any
//  counter near wrap, periodic timer. Sits between counter bank and AXI DMA packer.
// PARAMETERS
//  NUM_COUNTERS   115  number of event counters in the bank
//  COUNTER_WIDTH  7    width of each counter
//  NEAR_FULL_TH   120  a counter value >= this raises the near-full trigger
//  PERIOD         1024 cycles between periodic captures; 0 disables timer
// PORTS
//  clk            in   1                       clock
//  rst_n          in   1                       reset, synchronous, active-low
//  enable         in   1                       0: no new captures; in-flight packet still completes
//  trigger        in   1                       external capture request, level, sampled per cycle
//  counters       in   NUM_COUNTERS*COUNTER_WIDTH  flattened counter values, counter i at [i*CW +: CW]
//  clear_counters out  1                       1-cycle pulse; bank loads counter[i] <= event[i] that edge
//  snap_valid     out  1                       snapshot packet valid
//  snap_ready     in   1                       downstream accepts packet
//  snap_data      out  NUM_COUNTERS*COUNTER_WIDTH  captured counter values
//  snap_reason    out  3                       {timer, near_full, ext} causes for this capture
//  snap_dropped   out  8                       triggers missed since last packet, saturating
//  snap_wrap_risk out  1                       a counter reached NEAR_FULL_TH while capture blocked
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, timer 0, pending/drop/wrap-risk state 0.
//  - req = enable & (trigger | near_full | timer_hit | pend_timer); near_full =
//    OR over i of (counter[i] >= NEAR_FULL_TH), combinational from counters.
//  - FSM IDLE -> CAPTURE -> SEND -> IDLE.
//    IDLE: req in cycle T -> CAPTURE in T+1; reason bits registered from T.
//    CAPTURE (1 cycle): clear_counters=1; snap_data latched from counters at end
//      of this cycle (counts through T+1 inclusive); bank's clear loads that
//      cycle's events, so no event lost. Next: SEND.
//    SEND: snap_valid=1, snap_data/reason/dropped/wrap_risk stable until
//      snap_valid & snap_ready; on that edge -> IDLE, snap_valid=0 next cycle.
//    Min capture-to-capture spacing 3 cycles (ready held high).
//  - Timer: increments each cycle when PERIOD!=0; timer_hit when timer==PERIOD-1,
//    timer then wraps to 0. Timer restarts at 0 on every CAPTURE.
//    timer_hit outside IDLE sets pend_timer (cleared on CAPTURE).
//  - Drops: each cycle in CAPTURE/SEND with trigger=1 & enable=1 increments drop
//    counter (saturates 255); value copied to snap_dropped in CAPTURE, then cleared.
//  - Wrap risk: near_full while in SEND sets sticky flag; copied to
//    snap_wrap_risk at next CAPTURE, then cleared.
//  - Simultaneous causes: all set reason bits captured together, one packet.
//  - enable=0 in CAPTURE/SEND: packet completes normally; no new capture.
//  - rst_n low in any state: FSM IDLE next edge, snap_valid drops, packet discarded,
//    clear_counters 0.
//  - No combinational path snap_ready -> snap_valid.
// TESTING
//  1 trigger=1 cycle 10, ready=1 -> clear_counters cycle 11, snap_valid cycle 12,
//    reason=3'b001, snap_data = counts through cycle 11; next counts start from 0.
//  2 counter[5] reaches 120 with no trigger -> capture, reason=3'b010; counter[5]
//    in snap_data =120+events through CAPTURE cycle.
//  3 PERIOD=16, no other input -> packet every 16 cycles, reason=3'b100, timer restarts.
//  4 ready=0 for 300 cycles, trigger held high -> snap_data stable, snap_dropped of
//    next packet =255; counter near-full during hold -> next snap_wrap_risk=1.
//  5 trigger and near_full same cycle -> single packet reason=3'b011; events
//    counted continuously across clear sum exactly to stimulus total.
//  6 rst_n low mid-SEND -> snap_valid=0 after edge, FSM IDLE, drop/wrap state 0.

Source files
------------

// File: rtl/pec_snapshot_controller.sv
// pec_snapshot_controller
// Sequences the performance event counter bank: decides when to snapshot the
// counters, clears them in the same cycle the snapshot is taken (the bank loads
// that cycle's events on clear, so nothing is lost), and hands the snapshot to
// the DMA packer over a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a capture request (ext, near-full, timer)
// ST_CAPTURE | one cycle: pulse clear_counters, latch counters into snap_data
// ST_SEND    | snap_valid high, packet held stable until snap_ready
module pec_snapshot_controller #(
   parameter int NUM_COUNTERS  = 115,
   parameter int COUNTER_WIDTH = 7,
   parameter int NEAR_FULL_TH  = 120,
   parameter int PERIOD        = 1024
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    enable,
   input  logic                                    trigger,
   input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]   counters,
   output logic                                    clear_counters,
   output logic                                    snap_valid,
   input  logic                                    snap_ready,
   output logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]   snap_data,
   output logic [2:0]                              snap_reason,
   output logic [7:0]                              snap_dropped,
   output logic                                    snap_wrap_risk
);

   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic          TIMER_EN   = (PERIOD != 0);
   localparam logic [TW-1:0] TIMER_LAST = TW'((PERIOD > 0) ? PERIOD - 1 : 0);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_SEND    = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [TW-1:0] timer;
   logic          timer_hit;
   logic          pend_timer;
   logic          near_full;
   logic          req;
   logic          go_capture;
   logic          trig_en;
   logic [7:0]    drop_cnt;
   logic          wrap_sticky;

   // near-full trigger: any counter at or above the threshold
   always_comb begin
      near_full = 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (int'(counters[i*COUNTER_WIDTH +: COUNTER_WIDTH]) >= NEAR_FULL_TH) begin
            near_full = 1'b1;
         end
      end
   end

   assign timer_hit  = TIMER_EN && (timer == TIMER_LAST);
   assign req        = enable & (trigger | near_full | timer_hit | pend_timer);
   assign go_capture = (state == ST_IDLE) && req;
   assign trig_en    = trigger & enable;

   // state decode drives the handshake directly; snap_ready only reaches state_nxt
   assign clear_counters = (state == ST_CAPTURE);
   assign snap_valid     = (state == ST_SEND);

   // next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (req) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_SEND;
         ST_SEND:    if (snap_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // periodic timer: wraps on hit, and starts from zero when a capture begins
   always_ff @(posedge clk) begin
      if (!rst_n || !TIMER_EN) begin
         timer <= '0;
      end else if (go_capture || timer_hit) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // a timer hit that arrives while busy is remembered until the next capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_timer <= 1'b0;
      end else if (state == ST_CAPTURE) begin
         pend_timer <= 1'b0;
      end else if (timer_hit && (state != ST_IDLE)) begin
         pend_timer <= 1'b1;
      end
   end

   // reason bits are taken from the request cycle itself
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_reason <= 3'b000;
      end else if (go_capture) begin
         snap_reason <= {timer_hit | pend_timer, near_full, trigger};
      end
   end

   // snapshot latched at the end of the clear cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_data <= '0;
      end else if (state == ST_CAPTURE) begin
         snap_data <= counters;
      end
   end

   // missed triggers while busy; a trigger during CAPTURE belongs to the next packet
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt     <= 8'd0;
         snap_dropped <= 8'd0;
      end else if (state == ST_CAPTURE) begin
         snap_dropped <= drop_cnt;
         drop_cnt     <= trig_en ? 8'd1 : 8'd0;
      end else if ((state == ST_SEND) && trig_en && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // a counter near wrap while the packet is held means its count may have wrapped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrap_sticky    <= 1'b0;
         snap_wrap_risk <= 1'b0;
      end else if (state == ST_CAPTURE) begin
         snap_wrap_risk <= wrap_sticky;
         wrap_sticky    <= 1'b0;
      end else if ((state == ST_SEND) && near_full) begin
         wrap_sticky <= 1'b1;
      end
   end

endmodule
